// File: rtl/button_event_gen.sv
// button_event_gen: turns debounced button levels into one-cycle command pulses
//   Up/down fire on press and auto-repeat while held; select fires once per press.
//   Up/down share one arbitration FSM that locks out conflicting presses.
//   Optional feature macro: AUTOREPEAT_EN (undefined: no repeat pulses, repeat_active = 0).
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   au/dis/sel    in   debounced increase / decrease / select levels
//   inc_pulse     out  one-cycle increase command
//   dec_pulse     out  one-cycle decrease command
//   sel_pulse     out  one-cycle select command
//   repeat_active out  high while the FSM is in REPEAT
module button_event_gen #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic au,
    input  logic dis,
    input  logic sel,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic sel_pulse,
    output logic repeat_active
);
    if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 ||
        HOLD_CYCLES - 1 >= (1 << CNT_W) || REPEAT_CYCLES - 1 >= (1 << CNT_W)) begin : g_bad_cfg
        $error("button_event_gen: invalid HOLD_CYCLES/REPEAT_CYCLES/CNT_W");
    end
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPEAT, S_LOCK} state_t;
    state_t state_q, state_d;
    logic dir_q, dir_d;
    logic au_q, dis_q, sel_q;
    logic inc_q, inc_d, dec_q, dec_d, sel_pulse_q;
    logic rise_au, rise_dis, active, other;
    assign rise_au  = au & ~au_q;
    assign rise_dis = dis & ~dis_q;
    // dir selects which button owns the FSM; the other one is the conflicting press
    assign active   = dir_q ? dis : au;
    assign other    = dir_q ? au : dis;
`ifdef AUTOREPEAT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_last;
    logic rep_q;
    assign cnt_last = (state_q == S_WAIT) ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(REPEAT_CYCLES - 1);
`endif
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
`ifdef AUTOREPEAT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (au && dis)
                    state_d = S_LOCK;
                else if (rise_au || rise_dis) begin
                    state_d = S_WAIT;
                    dir_d   = rise_dis;
                    inc_d   = rise_au;
                    dec_d   = rise_dis;
`ifdef AUTOREPEAT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT, S_REPEAT: begin
                if (!active)
                    state_d = S_IDLE;
                else if (other)
                    state_d = S_LOCK;
`ifdef AUTOREPEAT_EN
                else if (cnt_q == cnt_last) begin
                    state_d = S_REPEAT;
                    inc_d   = ~dir_q;
                    dec_d   = dir_q;
                    cnt_d   = '0;
                end else
                    cnt_d = cnt_q + 1'b1;
`endif
            end
            S_LOCK: if (!au && !dis) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dir_q       <= 1'b0;
            au_q        <= 1'b1;
            dis_q       <= 1'b1;
            sel_q       <= 1'b1;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            sel_pulse_q <= 1'b0;
`ifdef AUTOREPEAT_EN
            cnt_q       <= '0;
            rep_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            au_q        <= au;
            dis_q       <= dis;
            sel_q       <= sel;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            sel_pulse_q <= sel & ~sel_q;
`ifdef AUTOREPEAT_EN
            cnt_q       <= cnt_d;
            rep_q       <= state_d == S_REPEAT;
`endif
        end
    end
    assign inc_pulse = inc_q;
    assign dec_pulse = dec_q;
    assign sel_pulse = sel_pulse_q;
`ifdef AUTOREPEAT_EN
    assign repeat_active = rep_q;
`else
    assign repeat_active = 1'b0;
`endif
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: directed self-checking bench for button_event_gen (HOLD=8, REPEAT=4)
module tb_button_event_gen;
`ifdef AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, au = 1'b0, dis = 1'b0, sel = 1'b0;
    logic inc_pulse, dec_pulse, sel_pulse, repeat_active;
    int checks = 0, failures = 0;

    button_event_gen #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .au(au), .dis(dis), .sel(sel),
        .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .sel_pulse(sel_pulse),
        .repeat_active(repeat_active)
    );

    always #5 clk = ~clk;

    // expected vector order: {inc, dec, sel, repeat_active}
    task automatic chk(input string tag, input logic [3:0] e);
        logic [3:0] o;
        o = {inc_pulse, dec_pulse, sel_pulse, repeat_active};
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic cyc(input logic a, input logic d, input logic s, input logic [3:0] e, input string tag);
        au = a;
        dis = d;
        sel = s;
        @(posedge clk);
        #1;
        chk(tag, e);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 4'b0000);
        reset = 1'b0;
        cyc(0, 0, 0, 4'b0000, "idle0");
        cyc(0, 0, 0, 4'b0000, "idle1");
        // short press: one inc pulse only
        cyc(1, 0, 0, 4'b1000, "short_press");
        cyc(1, 0, 0, 4'b0000, "short_hold1");
        cyc(1, 0, 0, 4'b0000, "short_hold2");
        cyc(0, 0, 0, 4'b0000, "short_release");
        cyc(0, 0, 0, 4'b0000, "short_idle");
        // long hold: pulses at 0, 8, 12, 16 with auto-repeat
        for (int i = 0; i < 20; i++)
            cyc(1, 0, 0, {(i == 0) || (AR && (i == 8 || i == 12 || i == 16)), 2'b00, AR && i >= 8},
                $sformatf("long_hold_%0d", i));
        cyc(0, 0, 0, 4'b0000, "long_release");
        cyc(0, 0, 0, 4'b0000, "long_idle");
        // both buttons rise together -> LOCK, no pulses
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 4'b0000, $sformatf("both_%0d", i));
        cyc(1, 0, 0, 4'b0000, "lock_au_only0");
        cyc(1, 0, 0, 4'b0000, "lock_au_only1");
        cyc(0, 0, 0, 4'b0000, "lock_exit");
        cyc(0, 0, 0, 4'b0000, "lock_idle");
        cyc(0, 1, 0, 4'b0100, "dis_after_lock");
        cyc(0, 0, 0, 4'b0000, "dis_release");
        cyc(0, 0, 0, 4'b0000, "dis_idle");
        // dis then au -> LOCK; sel still fires
        cyc(0, 1, 0, 4'b0100, "dis_press");
        cyc(0, 1, 0, 4'b0000, "dis_hold1");
        cyc(0, 1, 0, 4'b0000, "dis_hold2");
        cyc(1, 1, 0, 4'b0000, "au_conflict");
        cyc(1, 1, 0, 4'b0000, "lock_k4");
        cyc(1, 1, 1, 4'b0010, "sel_in_lock");
        cyc(1, 1, 1, 4'b0000, "sel_held");
        cyc(1, 1, 0, 4'b0000, "lock_k7");
        cyc(1, 1, 0, 4'b0000, "lock_k8_no_dec");
        cyc(1, 1, 0, 4'b0000, "lock_k9");
        cyc(0, 0, 0, 4'b0000, "lock_release");
        cyc(0, 0, 0, 4'b0000, "lock_release_idle");
        // hold into REPEAT, then asynchronous reset mid-cycle
        cyc(1, 0, 0, 4'b1000, "rst_press");
        for (int i = 1; i < 8; i++) cyc(1, 0, 0, 4'b0000, $sformatf("rst_hold_%0d", i));
        cyc(1, 0, 0, {AR, 2'b00, AR}, "rst_first_repeat");
        cyc(1, 0, 1, {2'b00, 1'b1, AR}, "rst_repeat_sel");
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", 4'b0000);
        @(posedge clk);
        #1;
        chk("reset_held", 4'b0000);
        reset = 1'b0;
        cyc(1, 0, 0, 4'b0000, "held_through_reset0");
        cyc(1, 0, 0, 4'b0000, "held_through_reset1");
        cyc(0, 0, 0, 4'b0000, "post_reset_release");
        cyc(1, 0, 0, 4'b1000, "post_reset_press");
        cyc(0, 0, 0, 4'b0000, "post_reset_done");
        // dis long hold gives dec repeats, never inc
        cyc(0, 1, 0, 4'b0100, "dis_long_0");
        for (int i = 1; i < 13; i++)
            cyc(0, 1, 0, {1'b0, AR && (i == 8 || i == 12), 1'b0, AR && i >= 8}, $sformatf("dis_long_%0d", i));
        cyc(0, 0, 0, 4'b0000, "dis_long_release");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Consumes the clean, debounced button levels (au, dis, sel) produced by the input anti-bounce stage.
- Converts them into single-cycle command pulses for the adjustment/menu logic.
- Up/down buttons fire once on press, then auto-repeat while held. Select fires once per press.
- Up/down share one arbitration FSM that locks out conflicting presses.

Parameters:
- HOLD_CYCLES, 50_000_000: cycles from first pulse to first repeat pulse (0.5 s at 100 MHz). Must be >= 2.
- REPEAT_CYCLES, 10_000_000: cycles between subsequent repeat pulses (0.1 s). Must be >= 2.
- CNT_W, 26: hold/repeat counter width. Must hold max(HOLD_CYCLES, REPEAT_CYCLES)-1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- au  input  1  debounced "increase" level
- dis  input  1  debounced "decrease" level
- sel  input  1  debounced "select" level
- inc_pulse  output  1  one-cycle increase command
- dec_pulse  output  1  one-cycle decrease command
- sel_pulse  output  1  one-cycle select command
- repeat_active  output  1  high while FSM is in REPEAT

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high.
- On reset, all outputs are 0, the FSM goes to IDLE and the counter is 0.
- The previous-value registers au_q, dis_q and sel_q reset to 1. A button held through reset therefore produces no pulse; it must be released and pressed again.
- Edge definition: a rising edge on X is X=1 and X_q=1'b0 at a clock edge. X_q <= X every cycle.
- All outputs are registered. A pulse is high for exactly the one cycle following the edge that decides it (latency 1).
- FSM states: IDLE, WAIT, REPEAT, LOCK, plus a dir bit (0 = up, 1 = down). The "active button" is au if dir=0, dis if dir=1.
- IDLE transitions:
  - au & dis both 1: go to LOCK, no pulse.
  - Rising edge on au with dis=0: inc_pulse, dir=0, cnt=0, go to WAIT.
  - Rising edge on dis with au=0: dec_pulse, dir=1, cnt=0, go to WAIT.
  - A level held high without a fresh edge does nothing.
- WAIT transitions, in priority order:
  - Active button released: go to IDLE, no pulse.
  - Other button high: go to LOCK.
  - cnt == HOLD_CYCLES-1: pulse for dir, cnt=0, go to REPEAT.
  - Otherwise cnt increments.
- REPEAT transitions: same priority as WAIT, but the terminal count is REPEAT_CYCLES-1 and the FSM stays in REPEAT after pulsing.
  - repeat_active=1 while in REPEAT; it asserts on the same edge that issues the first repeat pulse.
- LOCK: no inc/dec pulses. Go to IDLE only when au=0 and dis=0.
- Resulting pulse timing for a button first seen high at edge k and held: pulses after edges k, k+HOLD_CYCLES, k+HOLD_CYCLES+REPEAT_CYCLES, and so on.
- Simultaneous events:
  - Both buttons rising at the same edge: go to LOCK.
  - Release of the active button and press of the other at the same edge: go to IDLE. The other button then needs a fresh edge to fire.
- sel is independent of the FSM. sel_pulse fires on every sel rising edge, including during LOCK or REPEAT.
- inc_pulse and dec_pulse are never high in the same cycle.
- Reset mid-operation: takes effect immediately and asynchronously; no partial pulse is emitted.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- Defined: WAIT/REPEAT operate as described above.
- Undefined:
  - WAIT never pulses again; it holds until release (go to IDLE) or the other button is pressed (go to LOCK).
  - REPEAT is unreachable, repeat_active is tied to 0, and the counter may be removed.

Test Plan (HOLD_CYCLES=8, REPEAT_CYCLES=4, AUTOREPEAT_EN defined unless noted):
- au high for edges k..k+2, then low -> exactly one inc_pulse, after edge k; dec_pulse=0; repeat_active=0.
- au high for edges k..k+19 -> inc_pulse after edges k, k+8, k+12, k+16 (4 pulses); repeat_active=1 from k+8 until the release edge.
- au and dis rise at the same edge and are held 10 cycles; dis released while au still high; then both low; then dis pressed -> no pulses until the final dis press, which gives one dec_pulse.
- dis pressed at k (dec_pulse), au pressed at k+3 -> LOCK, no further dec_pulse at k+8. sel pressed during LOCK -> one sel_pulse, 1 cycle wide.
- au held into REPEAT, reset asserted mid-cycle -> all outputs 0 immediately. Reset released with au high -> no pulse. au low then high -> one inc_pulse.
- AUTOREPEAT_EN undefined, au held 30 cycles -> exactly one inc_pulse; repeat_active stays 0.
